// File: rtl/jtcps_mmr_bank_if.sv
// CPU-side bus of the CPS-A/CPS-B register bank: strobes, address,
// byte selects, write data and the registered CPS-B read data.
interface jtcps_mmr_bank_if #(
  parameter int AW = 5
);
  logic          cs_a;
  logic          cs_b;
  logic [AW-1:0] addr;
  logic [1:0]    dsn;
  logic [15:0]   din;
  logic [15:0]   dout;

  modport master (output cs_a, cs_b, addr, dsn, din, input dout);
  modport slave  (input cs_a, cs_b, addr, dsn, din, output dout);
endinterface

// File: rtl/jtcps_mmr_bank.sv
// CPS-A double-buffered registers, download-configured CPS-B registers,
// pipelined multiplier and object DMA / palette copy request handshakes.
module jtcps_mmr_bank #(
  parameter int              NA      = 18,
  parameter int              NB      = 8,
  parameter int              AW      = 5,
  parameter int              MLAT    = 2,
  parameter logic [NA-1:0]   IMMED   = 'h3_0021,
  parameter int              OBJ_IDX = 0,
  parameter int              PAL_IDX = 5
)(
  input  logic               rst,
  input  logic               clk,
  jtcps_mmr_bank_if.slave    bus,
  input  logic               vblank,
  input  logic               cfg_we,
  input  logic [7:0]         cfg_data,
  output logic [16*NA-1:0]   a_live,
  output logic [16*NB-1:0]   b_regs,
  output logic               obj_req,
  input  logic               obj_ack,
  output logic               pal_req,
  input  logic               pal_ack
);
  localparam int CL = 6 + NB;
  localparam int XW = (AW > 8) ? AW : 8;

  // config byte slots
  localparam int C_ID = 0, C_IDV = 1, C_M1 = 2, C_M2 = 3, C_R0 = 4, C_R1 = 5, C_B = 6;

  logic [7:0]    cfg [CL];
  logic [XW-1:0] ax;
  logic [15:0]   shadow [NA];
  logic [15:0]   live   [NA];
  logic [NA-1:0] a_wr;
  logic          vb_q, commit, pend;
  logic [15:0]   mult1, mult2, dout_r, rd;
  logic [15:0]   breg [NB];
  logic [31:0]   pp [MLAT];
  logic [31:0]   product;
  logic          w_m1, w_m2;
  logic [NB-1:0] w_b;

  // config bytes hold byte addresses; 8'hFF is the "unused" marker
  function automatic logic hit(input logic [7:0] b, input logic [XW-1:0] a);
    return (b != 8'hFF) && (a == XW'(b[7:1]));
  endfunction

  // dsn bit low means that byte lane is written
  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic [1:0] n);
    return {n[1] ? old[15:8] : d[15:8], n[0] ? old[7:0] : d[7:0]};
  endfunction

  assign ax      = XW'(bus.addr);
  assign commit  = vblank & ~vb_q;
  assign product = pp[MLAT-1];
  assign bus.dout = dout_r;

  generate
    for (genvar k = 0; k < NA; k++) begin : g_a
      assign a_wr[k]            = bus.cs_a && (ax == XW'(k));
      assign a_live[16*k +: 16] = live[k];
    end
    for (genvar k = 0; k < NB; k++) begin : g_b
      assign b_regs[16*k +: 16] = breg[k];
    end
  endgenerate

  // download-time config shift register; survives reset on purpose
  always_ff @(posedge clk) begin
    if (cfg_we) begin
      cfg[0] <= cfg_data;
      for (int i = 1; i < CL; i++) cfg[i] <= cfg[i-1];
    end
  end

  // vblank edge detector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vb_q <= 1'b0;
    else     vb_q <= vblank;
  end

  // CPS-A shadow/live update; a same-cycle write wins over the committed shadow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NA; k++) begin
        shadow[k] <= '0;
        live[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < NA; k++) begin
        if (a_wr[k]) shadow[k] <= merge(shadow[k], bus.din, bus.dsn);
        if (IMMED[k]) begin
          if (a_wr[k]) live[k] <= merge(shadow[k], bus.din, bus.dsn);
        end else if (commit) begin
          live[k] <= a_wr[k] ? merge(shadow[k], bus.din, bus.dsn) : shadow[k];
        end
      end
    end
  end

  // request handshakes; a new trigger write beats a same-cycle ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      obj_req <= 1'b0;
      pal_req <= 1'b0;
      pend    <= 1'b0;
    end else begin
      if (a_wr[OBJ_IDX])   obj_req <= 1'b1;
      else if (obj_ack)    obj_req <= 1'b0;
      // palette copy waits for the CPU to leave the bus
      if (pend && !bus.cs_a) begin
        pal_req <= 1'b1;
        pend    <= 1'b0;
      end else if (pal_ack) begin
        pal_req <= 1'b0;
      end
      if (a_wr[PAL_IDX])   pend <= 1'b1;
    end
  end

  // CPS-B address decode in priority order, read mux and write enables
  always_comb begin
    rd   = 16'hFFFF;
    w_m1 = 1'b0;
    w_m2 = 1'b0;
    w_b  = '0;
    if (hit(cfg[C_ID], ax))      rd = {4'd0, cfg[C_IDV][7:4], 4'd0, cfg[C_IDV][3:0]};
    else if (hit(cfg[C_M1], ax)) begin rd = mult1; w_m1 = 1'b1; end
    else if (hit(cfg[C_M2], ax)) begin rd = mult2; w_m2 = 1'b1; end
    else if (hit(cfg[C_R0], ax)) rd = product[15:0];
    else if (hit(cfg[C_R1], ax)) rd = product[31:16];
    else begin
      for (int k = NB-1; k >= 0; k--) begin
        if (hit(cfg[C_B+k], ax)) begin
          rd     = breg[k];
          w_b    = '0;
          w_b[k] = 1'b1;
        end
      end
    end
    if (&bus.addr) rd = 16'hFFFF;
  end

  // CPS-B registers and registered read port; only full-word writes land
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mult1  <= '0;
      mult2  <= '0;
      dout_r <= 16'hFFFF;
      for (int k = 0; k < NB; k++) breg[k] <= 16'hFFFF;
    end else if (bus.cs_b) begin
      dout_r <= rd;
      if (bus.dsn == 2'b00) begin
        if (w_m1) mult1 <= bus.din;
        if (w_m2) mult2 <= bus.din;
        for (int k = 0; k < NB; k++) if (w_b[k]) breg[k] <= bus.din;
      end
    end
  end

  // fully pipelined unsigned multiplier, MLAT register stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MLAT; i++) pp[i] <= '0;
    end else begin
      pp[0] <= 32'(mult1) * 32'(mult2);
      for (int i = 1; i < MLAT; i++) pp[i] <= pp[i-1];
    end
  end
endmodule
